// File: rtl/oam_dma_pkg.sv
// Shared state encoding and constants for the OAM sprite DMA engine.
package oam_dma_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      GET   = 3'd3,
      PUT   = 3'd4
   } dma_state_t;

   localparam logic [15:0] PUT_ADDR_DEFAULT = 16'h2004;
   localparam int          CNT_W            = 8;

endpackage

// File: rtl/oam_dma.sv
// OAM sprite DMA: a $4014 write halts the CPU and copies one 256-byte page to $2004.
// Optional status outputs (DMA_CNT, DMA_DONE) are enabled with OAM_DMA_STATUS_EN.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] PUT_ADDR = PUT_ADDR_DEFAULT
)
(
   input  logic              CLK,
   input  logic              RES,
   input  logic              W4014,
   input  logic [7:0]        DB_IN,
   input  logic              CPU_RNW,
   input  logic [7:0]        DMA_DIN,
   output logic              RDY,
   output logic [15:0]       DMA_ADDR,
   output logic              DMA_RD,
   output logic              DMA_WR,
   output logic [7:0]        DMA_DOUT,
   output logic              DMA_BUSY
`ifdef OAM_DMA_STATUS_EN
   ,
   output logic [CNT_W-1:0]  DMA_CNT,
   output logic              DMA_DONE
`endif
);

   dma_state_t       state_r;
   logic             phase_r;
   logic [CNT_W-1:0] cnt_r;
   logic [7:0]       page_r;
   logic [CNT_W-1:0] cnt_inc_s;

   assign cnt_inc_s = cnt_r + CNT_W'(1);

   // Get/put phase: GET always lands on phase 0, PUT on phase 1.
   always_ff @(posedge CLK) begin
      if (RES) begin
         phase_r <= 1'b0;
      end else begin
         phase_r <= ~phase_r;
      end
   end

   // Transfer FSM; outputs are registered alongside the state they belong to.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         page_r   <= 8'h00;
         RDY      <= 1'b1;
         DMA_ADDR <= 16'h0000;
         DMA_RD   <= 1'b0;
         DMA_WR   <= 1'b0;
         DMA_DOUT <= 8'h00;
         DMA_BUSY <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (W4014) begin
                  page_r   <= DB_IN;
                  state_r  <= HALT;
                  RDY      <= 1'b0;
                  DMA_BUSY <= 1'b1;
               end
            end
            // The CPU only stops on a read cycle, so writes keep us waiting here.
            HALT: begin
               if (CPU_RNW) begin
                  if (phase_r) begin
                     state_r  <= GET;
                     DMA_ADDR <= {page_r, cnt_r};
                     DMA_RD   <= 1'b1;
                  end else begin
                     state_r  <= ALIGN;
                  end
               end
            end
            ALIGN: begin
               state_r  <= GET;
               DMA_ADDR <= {page_r, cnt_r};
               DMA_RD   <= 1'b1;
            end
            GET: begin
               state_r  <= PUT;
               DMA_RD   <= 1'b0;
               DMA_WR   <= 1'b1;
               DMA_ADDR <= PUT_ADDR;
               DMA_DOUT <= DMA_DIN;
            end
            PUT: begin
               cnt_r  <= cnt_inc_s;
               DMA_WR <= 1'b0;
               if (cnt_r == {CNT_W{1'b1}}) begin
                  state_r  <= IDLE;
                  DMA_ADDR <= 16'h0000;
                  RDY      <= 1'b1;
                  DMA_BUSY <= 1'b0;
               end else begin
                  state_r  <= GET;
                  DMA_ADDR <= {page_r, cnt_inc_s};
                  DMA_RD   <= 1'b1;
               end
            end
            default: begin
               state_r  <= IDLE;
               cnt_r    <= '0;
               RDY      <= 1'b1;
               DMA_ADDR <= 16'h0000;
               DMA_RD   <= 1'b0;
               DMA_WR   <= 1'b0;
               DMA_BUSY <= 1'b0;
            end
         endcase
      end
   end

`ifdef OAM_DMA_STATUS_EN
   logic done_r;

   // Completion pulse in the cycle RDY comes back.
   always_ff @(posedge CLK) begin
      if (RES) begin
         done_r <= 1'b0;
      end else begin
         done_r <= (state_r == PUT) && (cnt_r == {CNT_W{1'b1}});
      end
   end

   assign DMA_CNT  = cnt_r;
   assign DMA_DONE = done_r;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Randomized self-checking bench for oam_dma against a transfer-level reference model.
module tb_oam_dma;

   logic        CLK = 1'b0;
   logic        RES = 1'b1;
   logic        W4014 = 1'b0;
   logic [7:0]  DB_IN = 8'h00;
   logic        CPU_RNW = 1'b1;
   logic [7:0]  DMA_DIN = 8'h00;
   logic        RDY;
   logic [15:0] DMA_ADDR;
   logic        DMA_RD;
   logic        DMA_WR;
   logic [7:0]  DMA_DOUT;
   logic        DMA_BUSY;
`ifdef OAM_DMA_STATUS_EN
   logic [7:0]  DMA_CNT;
   logic        DMA_DONE;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   logic ph = 1'b0;

   oam_dma dut (
      .CLK      (CLK),
      .RES      (RES),
      .W4014    (W4014),
      .DB_IN    (DB_IN),
      .CPU_RNW  (CPU_RNW),
      .DMA_DIN  (DMA_DIN),
      .RDY      (RDY),
      .DMA_ADDR (DMA_ADDR),
      .DMA_RD   (DMA_RD),
      .DMA_WR   (DMA_WR),
      .DMA_DOUT (DMA_DOUT),
      .DMA_BUSY (DMA_BUSY)
`ifdef OAM_DMA_STATUS_EN
      ,
      .DMA_CNT  (DMA_CNT),
      .DMA_DONE (DMA_DONE)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One CPU cycle; ph tracks the phase of the cycle now being observed.
   task automatic step();
      @(posedge CLK);
      ph = RES ? 1'b0 : ~ph;
      @(negedge CLK);
   endtask

   task automatic xfer(input logic [7:0] page, input logic [7:0] salt, input int n_wr,
                       input int want_ph, input int abort_put, input bit poke);
      logic [15:0] gets[$];
      logic [23:0] puts[$];
      int   cyc = 0, lowcnt = 0, first_get = -1, wr_left = n_wr, align;
      int   bad_ph = 0, bad_busy = 0, bad_both = 0, n_exp, act;
      logic halt_ph = 1'b0;
      bit   halt_seen = 1'b0;
      if (want_ph < 2) begin
         while (ph != (want_ph[0] ^ ~n_wr[0])) step();
      end
      W4014 = 1'b1; DB_IN = page; CPU_RNW = 1'b0;
      step();
      W4014 = 1'b0; DB_IN = 8'($urandom);
      while (RDY === 1'b0 && cyc < 2000) begin
         lowcnt++;
         if (DMA_BUSY !== 1'b1) bad_busy++;
         if (DMA_RD === 1'b1 && DMA_WR === 1'b1) bad_both++;
         if (DMA_RD === 1'b1) begin
            gets.push_back(DMA_ADDR);
            if (first_get < 0) first_get = cyc;
            if (ph !== 1'b0) bad_ph++;
         end
         if (DMA_WR === 1'b1) puts.push_back({DMA_ADDR, DMA_DOUT});
         DMA_DIN = DMA_ADDR[7:0] ^ salt;
         CPU_RNW = (wr_left == 0);
         if (wr_left == 0 && !halt_seen) begin
            halt_seen = 1'b1;
            halt_ph = ph;
         end
         if (wr_left > 0) wr_left--;
         W4014 = poke && (cyc == 37);
         if (poke && cyc == 37) DB_IN = 8'h07;
         RES = (abort_put >= 0) && (DMA_WR === 1'b1) && (puts.size() == abort_put + 1);
         step();
         cyc++;
      end
      RES = 1'b0; W4014 = 1'b0;
      if (cyc >= 2000) chk_val("timeout", 32'd1, 32'd0);
      align = halt_ph ? 0 : 1;
      n_exp = (abort_put >= 0) ? abort_put + 1 : 256;
      chk_val("rdy_low_cycles", lowcnt, n_wr + 1 + align + 2 * n_exp);
      chk_val("first_get_cycle", first_get, n_wr + 1 + align);
      chk_val("get_count", gets.size(), n_exp);
      chk_val("put_count", puts.size(), n_exp);
      chk_val("get_phase", bad_ph, 0);
      chk_val("busy_while_halted", bad_busy, 0);
      chk_val("rd_wr_overlap", bad_both, 0);
      for (int i = 0; i < gets.size() && i < 256; i++)
         chk_val("get_addr", gets[i], {page, 8'(i)});
      for (int i = 0; i < puts.size() && i < 256; i++)
         chk_val("put_addr_data", puts[i], {16'h2004, 8'(i) ^ salt});
      chk_val("rdy_after", RDY, 1'b1);
      chk_val("busy_after", DMA_BUSY, 1'b0);
      chk_val("wr_after", DMA_WR, 1'b0);
      chk_val("addr_after", DMA_ADDR, 16'h0000);
`ifdef OAM_DMA_STATUS_EN
      chk_val("cnt_after", DMA_CNT, 8'h00);
      chk_val("done_pulse", DMA_DONE, (abort_put >= 0) ? 1'b0 : 1'b1);
`endif
      act = 0;
      for (int i = 0; i < 12; i++) begin
         if (DMA_RD !== 1'b0 || DMA_WR !== 1'b0 || RDY !== 1'b1) act++;
         step();
      end
      chk_val("idle_after", act, 0);
   endtask

   initial begin
      step(); step();
      RES = 1'b0;
      chk_val("reset_rdy", RDY, 1'b1);
      chk_val("reset_rd", DMA_RD, 1'b0);
      chk_val("reset_wr", DMA_WR, 1'b0);
      chk_val("reset_addr", DMA_ADDR, 16'h0000);
      chk_val("reset_dout", DMA_DOUT, 8'h00);
      chk_val("reset_busy", DMA_BUSY, 1'b0);
`ifdef OAM_DMA_STATUS_EN
      chk_val("reset_cnt", DMA_CNT, 8'h00);
      chk_val("reset_done", DMA_DONE, 1'b0);
`endif
      // W4014 coinciding with RES must not start a transfer.
      W4014 = 1'b1; DB_IN = 8'h55; RES = 1'b1;
      step();
      W4014 = 1'b0; RES = 1'b0;
      chk_val("res_wins_busy", DMA_BUSY, 1'b0);
      step();
      chk_val("res_wins_rdy", RDY, 1'b1);
      chk_val("res_wins_idle", DMA_BUSY, 1'b0);

      xfer(8'h02, 8'h5A, 0, 1, -1, 1'b0);
      xfer(8'h02, 8'h5A, 0, 0, -1, 1'b0);
      xfer(8'h11, 8'($urandom), 2, 2, -1, 1'b0);
      xfer(8'hFF, 8'($urandom), 0, 2, -1, 1'b0);
      xfer(8'h03, 8'($urandom), 0, 2, -1, 1'b1);
      xfer(8'h04, 8'($urandom), 0, 2, 100, 1'b0);
      for (int k = 0; k < 4; k++)
         xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
